// File: rtl/ema_xover_mc_if.sv
// rtl/ema_xover_mc_if.sv - tick/clear/result handshake bundle for ema_xover_mc
interface ema_xover_mc_if #(
    parameter int CHANNELS = 4,
    parameter int PRICE_W  = 32
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [CH_W-1:0]           in_chan;
    logic signed [PRICE_W-1:0] in_price;
    logic                      clr_valid;
    logic [CH_W-1:0]           clr_chan;
    logic                      out_valid;
    logic                      out_ready;
    logic [CH_W-1:0]           out_chan;
    logic signed [1:0]         out_signal;
    logic signed [PRICE_W:0]   out_diff;

    modport master (
        output in_valid, in_chan, in_price, clr_valid, clr_chan, out_ready,
        input  in_ready, out_valid, out_chan, out_signal, out_diff
    );

    modport slave (
        input  in_valid, in_chan, in_price, clr_valid, clr_chan, out_ready,
        output in_ready, out_valid, out_chan, out_signal, out_diff
    );
endinterface

// File: rtl/ema_xover_mc.sv
// rtl/ema_xover_mc.sv - multi-channel fast/slow EMA crossover signal pipeline
// Optional XOVER_ONLY_EN: emit results only on signal changes (crossover events).
module ema_xover_mc #(
    parameter int CHANNELS   = 4,
    parameter int PRICE_W    = 32,
    parameter int FAST_SHIFT = 4,
    parameter int SLOW_SHIFT = 6,
    parameter int WARMUP     = 64,
    parameter int HYST       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    ema_xover_mc_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W:0] WARMUP_C = (CNT_W + 1)'(WARMUP);
    localparam logic signed [PRICE_W+1:0] HYST_P = (PRICE_W + 2)'(HYST);
    localparam logic signed [PRICE_W+1:0] HYST_N = -HYST_P;

    logic signed [PRICE_W-1:0] fast_q [CHANNELS];
    logic signed [PRICE_W-1:0] slow_q [CHANNELS];
    logic [CNT_W-1:0]          cnt_q  [CHANNELS];
    logic signed [1:0]         last_q [CHANNELS];
    logic                      first_q[CHANNELS];

    logic                      s1_valid;
    logic [CH_W-1:0]           s1_chan;
    logic signed [PRICE_W:0]   s1_diff;
    logic signed [1:0]         s1_sig;
    logic                      s1_emit;
`ifdef XOVER_ONLY_EN
    logic                      s1_evt;
`endif

    logic advance, accept, chan_ok, clr_ok;
    logic [CH_W-1:0] idx, clr_idx;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && !bus.clr_valid;
    assign accept       = bus.in_valid && bus.in_ready;
    assign chan_ok      = int'(bus.in_chan) < CHANNELS;
    assign clr_ok       = int'(bus.clr_chan) < CHANNELS;
    // Out-of-range ids still read channel 0 state; chan_ok blocks every write.
    assign idx          = chan_ok ? bus.in_chan : '0;
    assign clr_idx      = clr_ok ? bus.clr_chan : '0;

    logic signed [PRICE_W-1:0] fast_cur, slow_cur, fast_new, slow_new;
    logic signed [PRICE_W:0]   fast_d, slow_d, fast_step, slow_step, diff_new;
    logic signed [PRICE_W+1:0] diff_ext;
    logic signed [1:0]         sig_new;
    logic [CNT_W:0]            cnt_inc;
    logic [CNT_W-1:0]          cnt_new;
    logic                      emit_new;

    always_comb begin
        fast_cur  = fast_q[idx];
        slow_cur  = slow_q[idx];
        fast_d    = {bus.in_price[PRICE_W-1], bus.in_price} - {fast_cur[PRICE_W-1], fast_cur};
        slow_d    = {bus.in_price[PRICE_W-1], bus.in_price} - {slow_cur[PRICE_W-1], slow_cur};
        fast_step = fast_d >>> FAST_SHIFT;
        slow_step = slow_d >>> SLOW_SHIFT;
        if (first_q[idx]) begin
            fast_new = bus.in_price;
            slow_new = bus.in_price;
        end else begin
            fast_new = fast_cur + fast_step[PRICE_W-1:0];
            slow_new = slow_cur + slow_step[PRICE_W-1:0];
        end
        diff_new = {fast_new[PRICE_W-1], fast_new} - {slow_new[PRICE_W-1], slow_new};
        diff_ext = {diff_new[PRICE_W], diff_new};
        if (diff_ext > HYST_P) begin
            sig_new = 2'sb01;
        end else if (diff_ext < HYST_N) begin
            sig_new = 2'sb11;
        end else begin
            sig_new = last_q[idx];
        end
        cnt_inc  = {1'b0, cnt_q[idx]} + 1'b1;
        emit_new = cnt_inc >= WARMUP_C;
        cnt_new  = (cnt_inc > WARMUP_C) ? WARMUP_C[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
    end

    // Channel state is written on the accept edge, so a following tick on the
    // same channel reads the updated EMAs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                fast_q[i]  <= '0;
                slow_q[i]  <= '0;
                cnt_q[i]   <= '0;
                last_q[i]  <= '0;
                first_q[i] <= 1'b1;
            end
        end else if (bus.clr_valid) begin
            if (clr_ok) begin
                fast_q[clr_idx]  <= '0;
                slow_q[clr_idx]  <= '0;
                cnt_q[clr_idx]   <= '0;
                last_q[clr_idx]  <= '0;
                first_q[clr_idx] <= 1'b1;
            end
        end else if (accept && chan_ok) begin
            fast_q[idx]  <= fast_new;
            slow_q[idx]  <= slow_new;
            cnt_q[idx]   <= cnt_new;
            last_q[idx]  <= sig_new;
            first_q[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_chan        <= '0;
            s1_diff        <= '0;
            s1_sig         <= '0;
            s1_emit        <= 1'b0;
`ifdef XOVER_ONLY_EN
            s1_evt         <= 1'b0;
`endif
            bus.out_valid  <= 1'b0;
            bus.out_chan   <= '0;
            bus.out_signal <= '0;
            bus.out_diff   <= '0;
        end else if (advance) begin
            s1_valid <= accept && chan_ok;
            if (accept && chan_ok) begin
                s1_chan <= bus.in_chan;
                s1_diff <= diff_new;
                s1_sig  <= sig_new;
                s1_emit <= emit_new;
`ifdef XOVER_ONLY_EN
                s1_evt  <= sig_new != last_q[idx];
`endif
            end
`ifdef XOVER_ONLY_EN
            bus.out_valid <= s1_valid && s1_emit && s1_evt;
`else
            bus.out_valid <= s1_valid && s1_emit;
`endif
            if (s1_valid) begin
                bus.out_chan   <= s1_chan;
                bus.out_signal <= s1_sig;
                bus.out_diff   <= s1_diff;
            end
        end
    end
endmodule

// File: tb/tb_ema_xover_mc.sv
// tb/tb_ema_xover_mc.sv - scoreboard bench for ema_xover_mc (HYST=0 and HYST=40000 instances)
module tb_ema_xover_mc;
    localparam int CH     = 4;
    localparam int PW     = 32;
    localparam int FS     = 4;
    localparam int SS     = 6;
    localparam int WU     = 64;
    localparam int HYST_B = 40000;
    localparam int P100   = 32'h0064_0000;
    localparam int P110   = 32'h006E_0000;
    localparam int P90    = 32'h005A_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ema_xover_mc_if #(.CHANNELS(CH), .PRICE_W(PW)) m_if ();
    ema_xover_mc_if #(.CHANNELS(CH), .PRICE_W(PW)) h_if ();

    ema_xover_mc #(.CHANNELS(CH), .PRICE_W(PW), .FAST_SHIFT(FS), .SLOW_SHIFT(SS),
                   .WARMUP(WU), .HYST(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(m_if.slave));

    ema_xover_mc #(.CHANNELS(CH), .PRICE_W(PW), .FAST_SHIFT(FS), .SLOW_SHIFT(SS),
                   .WARMUP(WU), .HYST(HYST_B)) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(h_if.slave));

    // Second instance sees exactly the ticks the first one accepts.
    assign h_if.in_valid  = m_if.in_valid && m_if.in_ready;
    assign h_if.in_chan   = m_if.in_chan;
    assign h_if.in_price  = m_if.in_price;
    assign h_if.clr_valid = m_if.clr_valid;
    assign h_if.clr_chan  = m_if.clr_chan;
    assign h_if.out_ready = 1'b1;

    typedef struct {
        int     ch;
        int     sig;
        longint diff;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int mf[2][CH];
    int ms[2][CH];
    int mc[2][CH];
    int ml[2][CH];
    bit mfirst[2][CH];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear(input int ch);
        for (int k = 0; k < 2; k++) begin
            mf[k][ch] = 0; ms[k][ch] = 0; mc[k][ch] = 0; ml[k][ch] = 0; mfirst[k][ch] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) model_clear(c);
        q0.delete();
        q1.delete();
    endtask

    task automatic model_tick(input int ch, input int price);
        longint d;
        longint diff;
        int     h;
        int     sig;
        int     prev;
        bit     emit;
        exp_t   e;
        for (int k = 0; k < 2; k++) begin
            h = (k == 0) ? 0 : HYST_B;
            if (mfirst[k][ch]) begin
                mf[k][ch] = price;
                ms[k][ch] = price;
                mfirst[k][ch] = 1'b0;
            end else begin
                d = longint'(price) - longint'(mf[k][ch]);
                mf[k][ch] = mf[k][ch] + int'(d >>> FS);
                d = longint'(price) - longint'(ms[k][ch]);
                ms[k][ch] = ms[k][ch] + int'(d >>> SS);
            end
            if (mc[k][ch] < WU) mc[k][ch]++;
            emit = mc[k][ch] >= WU;
            diff = longint'(mf[k][ch]) - longint'(ms[k][ch]);
            if (diff > h) sig = 1;
            else if (diff < -h) sig = -1;
            else sig = ml[k][ch];
            prev = ml[k][ch];
            ml[k][ch] = sig;
`ifdef XOVER_ONLY_EN
            emit = emit && (sig != prev);
`endif
            if (emit) begin
                e.ch = ch; e.sig = sig; e.diff = diff;
                if (k == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the tick is accepted.
    task automatic send(input int ch, input int price);
        int t;
        t = 0;
        m_if.in_valid = 1'b1;
        m_if.in_chan  = 2'(ch);
        m_if.in_price = price;
        #1;
        while (!m_if.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            chk("send_timeout", 1, 0);
        end else begin
            model_tick(ch, price);
        end
        @(negedge clk);
        m_if.in_valid = 1'b0;
    endtask

    task automatic clear(input int ch);
        m_if.clr_valid = 1'b1;
        m_if.clr_chan  = 2'(ch);
        #1;
        chk("in_ready_during_clear", m_if.in_ready, 0);
        model_clear(ch);
        @(negedge clk);
        m_if.clr_valid = 1'b0;
    endtask

    // Monitors sample between negedge and the next posedge, where handshakes are stable.
    logic              stall_prev = 1'b0;
    logic [1:0]        held_chan;
    logic signed [1:0] held_sig;
    logic signed [32:0] held_diff;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            if (stall_prev) begin
                chk("stall_out_valid", m_if.out_valid, 1);
                chk("stall_out_chan", m_if.out_chan, held_chan);
                chk("stall_out_signal", m_if.out_signal, held_sig);
                chk("stall_out_diff", m_if.out_diff, held_diff);
            end
            if (m_if.out_valid && !m_if.out_ready) begin
                chk("stall_in_ready", m_if.in_ready, 0);
                stall_prev = 1'b1;
                held_chan  = m_if.out_chan;
                held_sig   = m_if.out_signal;
                held_diff  = m_if.out_diff;
            end else begin
                stall_prev = 1'b0;
            end
            if (m_if.out_valid && m_if.out_ready) begin
                if (q0.size() == 0) begin
                    chk("h0_unexpected_output", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("h0_out_chan", m_if.out_chan, e.ch);
                    chk("h0_out_signal", m_if.out_signal, e.sig);
                    chk("h0_out_diff", m_if.out_diff, e.diff);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && h_if.out_valid) begin
            if (q1.size() == 0) begin
                chk("h40k_unexpected_output", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("h40k_out_chan", h_if.out_chan, e.ch);
                chk("h40k_out_signal", h_if.out_signal, e.sig);
                chk("h40k_out_diff", h_if.out_diff, e.diff);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, m_if.out_valid, 0);
        chk({tag, "_out_chan"}, m_if.out_chan, 0);
        chk({tag, "_out_signal"}, m_if.out_signal, 0);
        chk({tag, "_out_diff"}, m_if.out_diff, 0);
        chk({tag, "_h_out_valid"}, h_if.out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_if.in_valid  = 1'b0;
        m_if.in_chan   = '0;
        m_if.in_price  = '0;
        m_if.clr_valid = 1'b0;
        m_if.clr_chan  = '0;
        m_if.out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_in_ready", m_if.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Warm-up on constant price, then step up and drop down.
        repeat (66) send(0, P100);
        send(0, P110);
        send(0, P110);
        repeat (12) send(0, P90);

        // Round-robin with back-to-back same-channel ticks.
        for (int r = 0; r < 70; r++) begin
            send(1, 32'h0020_0000);
            send(2, 32'h0050_0000 - r * 32'h0000_4000);
            send(3, 32'h0030_0000 + r * 32'h0000_8000);
            send(0, P90);
            if (r % 8 == 3) begin
                send(1, 32'h0020_0000 + r * 32'h0000_1000);
                send(1, 32'h0020_0000 + r * 32'h0000_2000);
            end
        end

        // Downstream stall for 5 cycles mid-stream.
        fork
            begin
                repeat (3) @(negedge clk);
                m_if.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                m_if.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) send(i % 4, 32'h0040_0000 + i * 32'h0001_0000);
            end
        join

        // Clear ch2 with a ch2 result still in flight, then re-warm it.
        send(2, 32'h0045_0000);
        clear(2);
        for (int i = 0; i < 66; i++) begin
            send(2, 32'h0010_0000 + i * 32'h0000_2000);
            if (i % 16 == 0) send(1, 32'h0021_0000);
        end

        // Async reset with ticks in flight.
        send(0, P110);
        send(1, P110);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (65) send(0, P100);
        send(3, P90);

        repeat (10) @(negedge clk);
        chk("q_h0_drained", q0.size(), 0);
        chk("q_h40k_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
